// File: rtl/mac_seq18_if.sv
// rtl/mac_seq18_if.sv - control, memory and accumulator signals of the MAC sequencer
interface mac_seq18_if #(
  parameter int TAP_W = 5
);
  logic             start;
  logic [TAP_W-1:0] num_taps;
  logic [TAP_W-1:0] addr;
  logic [15:0]      smpl;
  logic [15:0]      coef;
  logic             acc_en;
  logic [17:0]      newSum;
  logic [17:0]      accum;
  logic             busy;
  logic             done;
  logic [15:0]      result;

  // Sequencer side: drives memory address, accumulator load and status
  modport master (
    input  start, num_taps, smpl, coef, accum,
    output addr, acc_en, newSum, busy, done, result
  );

  // Environment side: host, memories and accumulator register
  modport slave (
    output start, num_taps, smpl, coef, accum,
    input  addr, acc_en, newSum, busy, done, result
  );
endinterface

// File: rtl/mac_seq18.sv
// rtl/mac_seq18.sv - sequential Q1.15 multiply-accumulate with external 18-bit accumulator
module mac_seq18 #(
  parameter int TAP_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq18_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    FETCH  = 3'd2,
    MAC    = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] n_q, n_d;
  logic [TAP_W-1:0] idx_q, idx_d;
  logic [TAP_W-1:0] addr_q, addr_d;
  logic [15:0]      result_q, result_d;
  logic             done_q, done_d;

  logic             acc_en;
  logic [17:0]      new_sum;

  // Datapath: Q1.15 x Q1.15 product scaled back by 15 bits, then an
  // 18-bit saturating add onto the current accumulator value.
  logic signed [31:0] prod;
  logic [17:0]        term;
  logic [18:0]        sum_w;
  logic [17:0]        mac_sum;
  logic [15:0]        acc_sat16;
  logic [TAP_W:0]     idx_inc;
  logic               unused_prod_lsbs;

  assign prod             = $signed(bus.smpl) * $signed(bus.coef);
  assign term             = {prod[31], prod[31:15]};
  assign unused_prod_lsbs = ^prod[14:0];
  assign sum_w            = {bus.accum[17], bus.accum} + {term[17], term};
  assign idx_inc          = {1'b0, idx_q} + (TAP_W + 1)'(1);

  // Saturate the 19-bit sum to 18 bits when the top two bits disagree
  always_comb begin
    mac_sum = sum_w[17:0];
    if (sum_w[18] != sum_w[17]) begin
      mac_sum = sum_w[18] ? 18'h20000 : 18'h1FFFF;
    end
  end

  // Saturate the accumulator to a 16-bit output sample
  always_comb begin
    acc_sat16 = bus.accum[15:0];
    if (!(bus.accum[17:15] == 3'b000 || bus.accum[17:15] == 3'b111)) begin
      acc_sat16 = bus.accum[17] ? 16'h8000 : 16'h7FFF;
    end
  end

  // State and holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state and accumulator-load decode; addr is loaded on entry to FETCH
  // so it is valid throughout FETCH and holds its value elsewhere.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    result_d = result_q;
    done_d   = 1'b0;
    acc_en   = 1'b0;
    new_sum  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = bus.num_taps;
          idx_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        acc_en = 1'b1;
        if (n_q != '0) begin
          addr_d  = idx_q;
          state_d = FETCH;
        end else begin
          state_d = FINISH;
        end
      end
      FETCH: begin
        state_d = MAC;
      end
      MAC: begin
        acc_en  = 1'b1;
        new_sum = mac_sum;
        idx_d   = idx_inc[TAP_W-1:0];
        if (idx_inc < {1'b0, n_q}) begin
          addr_d  = idx_inc[TAP_W-1:0];
          state_d = FETCH;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        result_d = acc_sat16;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.addr   = addr_q;
  assign bus.acc_en = acc_en;
  assign bus.newSum = new_sum;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mac_seq18.sv
// tb/tb_mac_seq18.sv - directed self-checking bench for mac_seq18
module tb_mac_seq18;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq18_if #(.TAP_W(TW)) bus ();
  mac_seq18 #(.TAP_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic signed [15:0] smem [32];
  logic signed [15:0] cmem [32];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Environment: cycle counter, registered memories, external accumulator
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.smpl <= smem[bus.addr];
    bus.coef <= cmem[bus.addr];
    if (rst) bus.accum <= 18'h2A5A5;
    else if (bus.acc_en) bus.accum <= bus.newSum;
  end

  function automatic void chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Run-level model: a run accepted in cycle s with N taps clears the
  // accumulator in s+1, fetches tap k in s+2+2k, loads partial sum k in
  // s+3+2k, and pulses done with the saturated result in s+2N+3.
  bit model_ok = 0;
  bit active = 0;
  int s0 = 0, rn = 0, run_res = 0, held_res = 0, exp_addr = 0;
  int psum [32];

  function automatic void plan(int n);
    int acc;
    longint p;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      p = longint'(smem[k]) * longint'(cmem[k]);
      acc = clamp(acc + int'(p >>> 15), -131072, 131071);
      psum[k] = acc;
    end
    run_res = clamp(acc, -32768, 32767);
  endfunction

  // Compare process: every cycle once reset has been seen
  always @(negedge clk) begin : cmp
    int d, eb, ed, ea, ens;
    if (model_ok) begin
      d = active ? cyc - s0 : -1;
      eb = (active && d >= 1 && d <= 2*rn + 2) ? 1 : 0;
      ed = (active && d == 2*rn + 3) ? 1 : 0;
      ea = 0;
      ens = 0;
      if (active && d == 1) ea = 1;
      if (active && d >= 3 && d <= 2*rn + 1 && (d % 2) == 1) begin
        ea = 1;
        ens = psum[(d - 3) / 2];
      end
      if (active && d >= 2 && d <= 2*rn && (d % 2) == 0) exp_addr = (d - 2) / 2;
      if (ed == 1) held_res = run_res;
      chk("busy", longint'(bus.busy), eb);
      chk("done", longint'(bus.done), ed);
      chk("acc_en", longint'(bus.acc_en), ea);
      if (ea == 1) chk("newSum", longint'($signed(bus.newSum)), ens);
      chk("addr", longint'(bus.addr), exp_addr);
      chk("result", longint'($signed(bus.result)), held_res);
      if (ed == 1) active = 0;
    end
    if (rst) begin
      model_ok = 1;
      active = 0;
      held_res = 0;
      exp_addr = 0;
    end else if (model_ok && !active && bus.start) begin
      s0 = cyc;
      rn = int'(bus.num_taps);
      plan(rn);
      active = 1;
    end
  end

  task automatic fill(input logic [15:0] s, input logic [15:0] c);
    for (int k = 0; k < 32; k++) begin
      smem[k] = s;
      cmem[k] = c;
    end
  endtask

  task automatic wait_done(output int dc, output int res);
    dc = -1;
    res = -99999;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dc = cyc;
        res = int'($signed(bus.result));
        break;
      end
    end
  endtask

  task automatic run(input string nm, input int n, input int exp_lat, input int exp_res);
    int t0, dc, res;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.num_taps = n[TW-1:0];
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.num_taps = '1;
    wait_done(dc, res);
    chk({nm, "_latency"}, dc - t0, exp_lat);
    chk({nm, "_result"}, res, exp_res);
  endtask

  initial begin : stim
    int t0, dc, dc2, res, ndone;
    bus.start = 1'b0;
    bus.num_taps = '0;
    fill(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_result", longint'(bus.result), 0);
    chk("rst_addr", longint'(bus.addr), 0);
    chk("rst_acc_en", longint'(bus.acc_en), 0);

    fill(16'h4000, 16'h4000);
    run("n1_half_sq", 1, 5, 8192);

    fill(16'h7FFF, 16'h7FFF);
    run("n4_max", 4, 11, 32767);

    fill(16'h8000, 16'h7FFF);
    run("n31_negclamp", 31, 65, -32768);

    run("n0", 0, 3, 0);

    fill(16'h0000, 16'h0000);
    smem[0] = 16'h2000; cmem[0] = 16'h4000;
    smem[1] = 16'hF000; cmem[1] = 16'h4000;
    smem[2] = 16'h7FFF; cmem[2] = 16'h0001;
    smem[3] = 16'hFFFF; cmem[3] = 16'h0001;
    run("n4_mixed", 4, 11, 2047);

    // Abort an N=8 run with reset in cycle 6
    fill(16'h4000, 16'h4000);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.num_taps = 5'd8;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_cycle", cyc - t0, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_acc_en", longint'(bus.acc_en), 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    fill(16'h4000, 16'h4000);
    run("restart_n1", 1, 5, 8192);

    // start held high through an N=2 run and re-accepted in the done cycle
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.num_taps = 5'd2;
    t0 = cyc;
    wait_done(dc, res);
    chk("hold_first_latency", dc - t0, 7);
    chk("hold_first_result", res, 16384);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(dc2, res);
    chk("hold_second_gap", dc2 - dc, 7);
    chk("hold_second_result", res, 16384);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
